flags_unit: RTL and testbench

FLAGS_UNIT -- requirements
Module: flags_unit

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/flags_unit_if.sv | 25 ++
 rtl/flags_unit_zero_detect.sv | 17 +
 rtl/flags_unit.sv | 62 ++++++
 tb/tb_flags_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch/condition encodings, NZCV bit indices and condition evaluator
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_HS, COND_LO,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Codes come in pairs: the odd member inverts the even one, except 111x which is always true.
    function automatic logic cond_holds(input cond_e c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n    = f[FLAG_N];
        z    = f[FLAG_Z];
        cf   = f[FLAG_C];
        v    = f[FLAG_V];
        base = (c[3:1] == 3'd0) ? z :
               (c[3:1] == 3'd1) ? cf :
               (c[3:1] == 3'd2) ? n :
               (c[3:1] == 3'd3) ? v :
               (c[3:1] == 3'd4) ? (cf & ~z) :
               (c[3:1] == 3'd5) ? (n == v) :
               (c[3:1] == 3'd6) ? (~z & (n == v)) : 1'b1;
        return (c[0] && c[3:1] != 3'd7) ? ~base : base;
    endfunction

endpackage

// File: rtl/flags_unit_if.sv
// flags_unit_if: groups the flags unit's execute-stage inputs and branch/flag outputs
interface flags_unit_if #(parameter int WIDTH = 64);
    logic [WIDTH-1:0] result;
    logic             carry_in;
    logic             ovf_in;
    logic             set_flags;
    logic [1:0]       br_type;
    logic [3:0]       cond;
    logic [WIDTH-1:0] cbz_operand;
    logic             stall;
    logic             flush;
    logic [3:0]       flags;
    logic             take_branch;
    logic             br_valid;

    modport master (
        output result, carry_in, ovf_in, set_flags, br_type, cond, cbz_operand, stall, flush,
        input  flags, take_branch, br_valid
    );

    modport slave (
        input  result, carry_in, ovf_in, set_flags, br_type, cond, cbz_operand, stall, flush,
        output flags, take_branch, br_valid
    );
endinterface

// File: rtl/flags_unit_zero_detect.sv
// zero_detect: wide zero test built from 16-bit NOR slices combined by a reduction tree
module zero_detect #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             zero_o
);
    localparam int CHUNKS = WIDTH / 16;

    logic [CHUNKS-1:0] chunk_zero;

    for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
        assign chunk_zero[g] = ~|data_i[16*g +: 16];
    end

    assign zero_o = &chunk_zero;
endmodule

// File: rtl/flags_unit.sv
// flags_unit: NZCV flag register plus registered B.cond / CBZ / CBNZ branch decision
module flags_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             set_flags,
    input  logic [1:0]       br_type,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] cbz_operand,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic             take_branch,
    output logic             br_valid
);
    logic       res_zero, cbz_zero, taken, is_branch;
    logic [3:0] nzcv, eval_nzcv;
    logic [3:0] flags_q, flags_d;
    logic       take_q, take_d, br_valid_q, br_valid_d;
    br_type_e   br;

    zero_detect #(.WIDTH(WIDTH)) u_res_zero (.data_i(result),      .zero_o(res_zero));
    zero_detect #(.WIDTH(WIDTH)) u_cbz_zero (.data_i(cbz_operand), .zero_o(cbz_zero));

    assign br = br_type_e'(br_type);

    // Branch decision uses same-cycle flags when this instruction also writes them; flush beats stall.
    always_comb begin
        nzcv       = {result[WIDTH-1], res_zero, carry_in, ovf_in};
        eval_nzcv  = (set_flags && !flush) ? nzcv : flags_q;
        is_branch  = (br != BR_NONE);
        taken      = (br == BR_COND) ? cond_holds(cond_e'(cond), eval_nzcv) :
                     (br == BR_CBZ)  ? cbz_zero :
                     (br == BR_CBNZ) ? ~cbz_zero : 1'b0;
        flags_d    = (set_flags && !stall && !flush) ? nzcv : flags_q;
        br_valid_d = flush ? 1'b0 : stall ? br_valid_q : is_branch;
        take_d     = flush ? 1'b0 : stall ? take_q : (taken & is_branch);
    end

    // State register; reset overrides stall, flush and set_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q    <= 4'b0000;
            take_q     <= 1'b0;
            br_valid_q <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            take_q     <= take_d;
            br_valid_q <= br_valid_d;
        end
    end

    assign flags       = flags_q;
    assign take_branch = take_q & br_valid_q;
    assign br_valid    = br_valid_q;
endmodule

// File: tb/tb_flags_unit.sv
// tb_flags_unit: scoreboard bench for flags_unit against an independent behavioural model
module tb_flags_unit;
    localparam int W = 64;

    typedef struct {
        string      tag;
        logic [3:0] f;
        logic       t;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    logic [3:0] m_flags = 4'b0;
    logic       m_take  = 1'b0;
    logic       m_valid = 1'b0;

    flags_unit_if #(.WIDTH(W)) bus ();

    flags_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(rst),
        .result(bus.result), .carry_in(bus.carry_in), .ovf_in(bus.ovf_in),
        .set_flags(bus.set_flags), .br_type(bus.br_type), .cond(bus.cond),
        .cbz_operand(bus.cbz_operand), .stall(bus.stall), .flush(bus.flush),
        .flags(bus.flags), .take_branch(bus.take_branch), .br_valid(bus.br_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Model the coming edge, push the expectation, clock, then pop and compare away from the edge.
    task automatic step(input string tag);
        logic [3:0] in_f, use_f;
        logic       dec;
        exp_t       e;
        in_f  = {bus.result[W-1], (bus.result == '0), bus.carry_in, bus.ovf_in};
        use_f = bus.set_flags ? in_f : m_flags;
        case (bus.br_type)
            2'b01:   dec = m_cond(bus.cond, use_f);
            2'b10:   dec = (bus.cbz_operand == '0);
            2'b11:   dec = (bus.cbz_operand != '0);
            default: dec = 1'b0;
        endcase
        if (rst) begin
            m_flags = 4'b0; m_take = 1'b0; m_valid = 1'b0;
        end else if (bus.flush) begin
            m_take = 1'b0; m_valid = 1'b0;
        end else if (!bus.stall) begin
            if (bus.set_flags) m_flags = in_f;
            m_valid = (bus.br_type != 2'b00);
            m_take  = m_valid && dec;
        end
        sb.push_back('{tag, m_flags, m_take, m_valid});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".flags"}, bus.flags, e.f);
        check({e.tag, ".take"}, {3'b0, bus.take_branch}, {3'b0, e.t});
        check({e.tag, ".valid"}, {3'b0, bus.br_valid}, {3'b0, e.v});
    endtask

    task automatic idle();
        bus.result = '1; bus.carry_in = 0; bus.ovf_in = 0; bus.set_flags = 0;
        bus.br_type = 2'b00; bus.cond = 4'd0; bus.cbz_operand = '0;
        bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        idle();
        rst = 1; bus.set_flags = 1; bus.result = '0; bus.br_type = 2'b01;
        step("reset0");
        step("reset1");
        check("reset_flags_const", bus.flags, 4'b0000);
        rst = 0; idle();
        step("idle");

        bus.result = 64'h8000_0000_0000_0000; bus.carry_in = 1; bus.set_flags = 1;
        step("set_1010");
        check("set_1010_const", bus.flags, 4'b1010);

        idle(); bus.set_flags = 1; bus.result = '0; bus.br_type = 2'b01; bus.cond = 4'd0;
        step("fwd_eq");
        check("fwd_eq_take", {3'b0, bus.take_branch}, 4'd1);

        idle(); bus.cbz_operand = 64'h0001_0000_0000_0000; bus.br_type = 2'b10;
        step("cbz_nz");
        bus.br_type = 2'b11;
        step("cbnz_nz");
        bus.cbz_operand = '0; bus.br_type = 2'b10;
        step("cbz_z");

        idle(); bus.set_flags = 1; bus.result = 64'h8000_0000_0000_0001;
        step("set_1000");
        check("set_1000_const", bus.flags, 4'b1000);
        idle(); bus.br_type = 2'b01; bus.cond = 4'd11;
        step("lt");
        bus.cond = 4'd10;
        step("ge");
        bus.cond = 4'd15;
        step("nv");

        idle(); bus.set_flags = 1; bus.result = '0; bus.flush = 1; bus.stall = 1; bus.br_type = 2'b10;
        step("flush_stall");
        check("flush_keeps_flags", bus.flags, 4'b1000);

        idle(); bus.br_type = 2'b11; bus.cbz_operand = 64'h5;
        step("pre_stall");
        idle(); bus.stall = 1; bus.set_flags = 1; bus.result = '0;
        for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
        check("stall_take_const", {3'b0, bus.take_branch}, 4'd1);

        rst = 1;
        step("reset_mid_stall");
        rst = 0; idle();

        for (int i = 0; i < 300; i++) begin
            bus.result      = {$urandom, $urandom};
            if ($urandom_range(3) == 0) bus.result = '0;
            if ($urandom_range(1) == 0) bus.result[W-1] = 1'b1;
            bus.carry_in    = 1'($urandom);
            bus.ovf_in      = 1'($urandom);
            bus.set_flags   = 1'($urandom);
            bus.br_type     = 2'($urandom);
            bus.cond        = 4'($urandom);
            bus.cbz_operand = ($urandom_range(2) == 0) ? '0 : {W{1'b0}} | (64'h1 << $urandom_range(W-1));
            bus.stall       = ($urandom_range(3) == 0);
            bus.flush       = ($urandom_range(7) == 0);
            rst             = ($urandom_range(24) == 0);
            step($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
